// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - shared encodings, state enum and seeds for the DDR gameplay engine
package ddr_pkg;

    localparam logic [2:0] L1 = 3'd1;
    localparam logic [2:0] L2 = 3'd2;
    localparam logic [2:0] L3 = 3'd3;
    localparam logic [2:0] L4 = 3'd4;

    localparam int BTN_L = 0;
    localparam int BTN_U = 1;
    localparam int BTN_D = 2;
    localparam int BTN_R = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_SHOW,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic [7:0] SEED_L1 = 8'h1D;
    localparam logic [7:0] SEED_L2 = 8'hA5;
    localparam logic [7:0] SEED_L3 = 8'h3C;
    localparam logic [7:0] SEED_L4 = 8'hE7;

    function automatic logic [7:0] level_seed(input logic [2:0] lev);
        case (lev)
            L2:      return SEED_L2;
            L3:      return SEED_L3;
            L4:      return SEED_L4;
            default: return SEED_L1;
        endcase
    endfunction

    function automatic logic lev_valid(input logic [2:0] lev);
        return (lev >= L1) && (lev <= L4);
    endfunction

endpackage

// File: rtl/ddr_arrow_lfsr.sv
// rtl/ddr_arrow_lfsr.sv - 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) producing a one-hot target arrow
module ddr_arrow_lfsr
    import ddr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       adv,
    output logic [3:0] target
);

    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed;
        end else if (adv) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    always_comb begin
        target = 4'b0000;
        case (lfsr_q[1:0])
            2'b00:   target[BTN_L] = 1'b1;
            2'b01:   target[BTN_U] = 1'b1;
            2'b10:   target[BTN_D] = 1'b1;
            default: target[BTN_R] = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 8'h00;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/ddr_gameplay.sv
// rtl/ddr_gameplay.sv - beat-grid arrow sequencer with hit/miss judgement, score and combo
module ddr_gameplay
    import ddr_pkg::*;
#(
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int NUM_STEPS   = 32,
    parameter int HIT_POINTS  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  lev,
    input  logic [3:0]  btn,
    output logic [3:0]  arrow,
    output logic        hit,
    output logic        miss,
    output logic [15:0] score,
    output logic [7:0]  combo,
    output logic        done
);

    localparam int             CW        = $clog2(BEAT_CYCLES + 1);
    localparam logic [CW-1:0]  BEAT      = CW'(BEAT_CYCLES);
    localparam logic [CW-1:0]  ONE       = CW'(1);
    localparam logic [7:0]     LAST_STEP = 8'(NUM_STEPS - 1);
    localparam logic [16:0]    PTS       = 17'(HIT_POINTS);

    state_t        state_q, state_d;
    logic [CW-1:0] period_q, period_d;
    logic [CW-1:0] window_q, window_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    step_q, step_d;
    logic          judged_q, judged_d;
    logic [3:0]    btn_prev_q, btn_prev_d;
    logic          hit_q, hit_d;
    logic          miss_q, miss_d;
    logic [15:0]   score_q, score_d;
    logic [7:0]    combo_q, combo_d;

    logic          lfsr_load, lfsr_adv;
    logic [3:0]    target;
    logic [3:0]    btn_edge;
    logic [4:0]    bonus;
    logic [16:0]   sum;

    ddr_arrow_lfsr u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (lfsr_load),
        .seed   (level_seed(lev)),
        .adv    (lfsr_adv),
        .target (target)
    );

    assign btn_prev_d = btn;
    assign btn_edge   = btn & ~btn_prev_q;
    assign bonus      = (combo_q > 8'd15) ? 5'd15 : combo_q[4:0];
    assign sum        = {1'b0, score_q} + PTS + 17'(bonus);

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        window_d  = window_q;
        cnt_d     = cnt_q;
        step_d    = step_q;
        judged_d  = judged_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        score_d   = score_q;
        combo_d   = combo_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && lev_valid(lev)) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end else begin
                    period_d  = BEAT >> (lev - 3'd1);
                    window_d  = (BEAT >> (lev - 3'd1)) >> 1;
                    lfsr_load = 1'b1;
                    score_d   = 16'h0000;
                    combo_d   = 8'h00;
                    step_d    = 8'h00;
                    cnt_d     = '0;
                    judged_d  = 1'b0;
                    state_d   = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end else begin
                    // The first nonzero edge in the window is final; silence until the last cycle is a miss.
                    if (!judged_q) begin
                        if (btn_edge != 4'b0000) begin
                            judged_d = 1'b1;
                            if (btn_edge == target) begin
                                hit_d   = 1'b1;
                                score_d = sum[16] ? 16'hFFFF : sum[15:0];
                                combo_d = (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;
                            end else begin
                                miss_d  = 1'b1;
                                combo_d = 8'h00;
                            end
                        end else if (cnt_q == window_q - ONE) begin
                            judged_d = 1'b1;
                            miss_d   = 1'b1;
                            combo_d  = 8'h00;
                        end
                    end
                    if (cnt_q == window_q - ONE) begin
                        cnt_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            ST_GAP: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == period_q - window_q - ONE) begin
                    cnt_d = '0;
                    if (step_q == LAST_STEP) begin
                        state_d = ST_DONE;
                    end else begin
                        step_d   = step_q + 8'd1;
                        lfsr_adv = 1'b1;
                        judged_d = 1'b0;
                        state_d  = ST_SHOW;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_DONE: begin
                if (!start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            period_q   <= '0;
            window_q   <= '0;
            cnt_q      <= '0;
            step_q     <= 8'h00;
            judged_q   <= 1'b0;
            btn_prev_q <= 4'b0000;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            score_q    <= 16'h0000;
            combo_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            window_q   <= window_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            judged_q   <= judged_d;
            btn_prev_q <= btn_prev_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            score_q    <= score_d;
            combo_q    <= combo_d;
        end
    end

    assign arrow = (state_q == ST_SHOW) ? target : 4'b0000;
    assign done  = (state_q == ST_DONE);
    assign hit   = hit_q;
    assign miss  = miss_q;
    assign score = score_q;
    assign combo = combo_q;

endmodule

// File: doc/ddr_gameplay.md
Name: ddr_gameplay

Overview:
- Gameplay engine for the DDR game.
- Sits directly downstream of the top-level level-select FSM, which supplies the chosen level and a start request and waits for done.
- Generates a per-level arrow sequence on a beat grid and judges each button press as hit or miss.
- Accumulates score and combo for the score display, and drives the current target arrow to graphics.

Parameters:
BEAT_CYCLES, 25_000_000, base beat period in clk cycles at level 1 (minimum 16).
NUM_STEPS, 32, number of arrows per song (1..255).
HIT_POINTS, 10, base points per hit.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  play request from the level-select FSM; level-sensitive
lev  input  3  level select, valid values 1..4
btn  input  4  debounced, clk-synchronous buttons; bit0=L, bit1=U, bit2=D, bit3=R
arrow  output  4  one-hot target arrow, 0 when none is shown
hit  output  1  one-cycle pulse on a correct judgement
miss  output  1  one-cycle pulse on an incorrect or absent judgement
score  output  16  accumulated score, saturating
combo  output  8  consecutive hits, saturating at 255
done  output  1  high while the song is complete

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE; arrow, hit, miss, done = 0; score, combo = 0; btn_prev = 0; step counter, cycle counter, LFSR = 0.
- Edge detection: edge = btn & ~btn_prev, with btn_prev registered every cycle. Only edges are judged.
- Beat timing, latched at ARM:
  - period = BEAT_CYCLES >> (lev-1)
  - window = period >> 1
- Arrow generator: 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1.
  - Seed per level: 1 -> 8'h1D, 2 -> 8'hA5, 3 -> 8'h3C, 4 -> 8'hE7.
  - Target = one-hot of lfsr[1:0] (00=L, 01=U, 10=D, 11=R).
  - LFSR advances exactly once per step, on the GAP->SHOW transition.
- States:
  - IDLE: when start=1 and lev in 1..4, go to ARM. lev 0 or 5..7 is ignored and the block stays in IDLE.
  - ARM (1 cycle): latch period and window, load seed, clear score/combo/step, then go to SHOW.
  - SHOW (window cycles): arrow = target. The first nonzero edge is the judgement:
    - edge == target: hit pulse; score += HIT_POINTS + min(combo,15); combo++.
    - any other nonzero edge, including multi-button edges and correct+wrong in the same cycle: miss pulse; combo = 0.
    - If no edge occurs by the last SHOW cycle, the miss pulse is issued on the SHOW->GAP transition.
    - After judgement, arrow stays displayed until the window ends; further edges are ignored.
  - GAP (period - window cycles): arrow = 0; edges are ignored. At the end:
    - step == NUM_STEPS-1: go to DONE.
    - otherwise: step++, advance LFSR, go to SHOW.
  - DONE: done = 1; score and combo hold. Return to IDLE when start = 0.
- Abort: start = 0 in ARM, SHOW or GAP returns to IDLE next cycle. Score is held, done is not asserted, and no judgement pulse is issued.
- Arithmetic:
  - score addition saturates at 16'hFFFF.
  - combo increment saturates at 255.
- hit and miss are never high in the same cycle. At most one judgement per step.
- Latency: a press edge in cycle t produces hit/miss in cycle t+1 (registered outputs).

Decomposition:
- Shared package ddr_pkg holds:
  - Level encodings (L1..L4 = 3'd1..3'd4).
  - Button bit indices (BTN_L=0, BTN_U=1, BTN_D=2, BTN_R=3).
  - Gameplay state enum.
  - Per-level LFSR seed constants.
- Sub-module ddr_arrow_lfsr: seed load, advance, and one-hot target output. Shared later with graphics preview.

Test Plan:
All scenarios use BEAT_CYCLES=16, NUM_STEPS=4.
- Perfect play, lev=1, start=1: first arrow=4'b0010 (U, seed 1D). Pressing the correct arrow in each SHOW gives 4 hit pulses, score 10,21,33,46, combo=4, done=1 at the end of the 4th GAP (16-cycle period).
- No input, lev=2 (period 8, window 4): 4 miss pulses, each at a SHOW->GAP boundary; score=0, combo=0, done=1.
- Wrong and multi-button edges: press a non-target arrow gives miss and combo reset. A later correct press in the same window gives no pulse. Pressing btn=4'b1111 in the next window gives a miss.
- Edges in GAP and repeats: a correct edge in GAP gives no pulse. A held button generates no second edge. Release and re-press after a judgement are ignored.
- Invalid lev=0 and lev=6 with start=1: the block stays IDLE, arrow=0, for 50 cycles.
- Mid-song controls:
  - start dropped in step 2: IDLE next cycle, score held, done stays 0.
  - rst asserted in SHOW: all outputs 0 on the next edge.
  - After DONE, start=0 returns to IDLE.
